// File: rtl/hazard_ctrl_unit.sv
// Hazard control unit: load-use stall and branch/jump flush sequencing.
// Optional feature macro HAZARD_PERF_CNT_EN adds perf_clr, lwstall_count and
// flush_count ports with free-running event counters.
module hazard_ctrl_unit #(
   parameter int unsigned LOAD_USE_STALLS     = 1,
   parameter int unsigned BRANCH_FLUSH_CYCLES = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       id_ex_memread,
   input  logic [4:0] id_ex_registerrt,
   input  logic [4:0] if_id_register_rs,
   input  logic [4:0] if_id_registerrt,
   input  logic       id_uses_rt,
   input  logic       mem_branch_taken,
   input  logic       mem_jump,
   output logic       pc_write,
   output logic       if_id_write,
   output logic       if_flush,
   output logic       id_flush_lwstall,
   output logic       id_flush_branch,
   output logic       ex_flush,
   output logic       stall_active
`ifdef HAZARD_PERF_CNT_EN
   ,
   input  logic        perf_clr,
   output logic [31:0] lwstall_count,
   output logic [31:0] flush_count
`endif
);

   localparam int unsigned CNT_W = 2;
   localparam logic [CNT_W-1:0] LW_INIT = CNT_W'(LOAD_USE_STALLS - 1);
   localparam logic [CNT_W-1:0] BR_INIT = CNT_W'(BRANCH_FLUSH_CYCLES - 1);
   localparam bit LW_MULTI = (LOAD_USE_STALLS > 1);
   localparam bit BR_MULTI = (BRANCH_FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      LW_STALL = 2'd1,
      BR_FLUSH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br;
   logic             load_use;

   // Redirect and load-use detection; register 0 never creates a dependency.
   always_comb begin
      br       = mem_branch_taken | mem_jump;
      load_use = id_ex_memread && (id_ex_registerrt != 5'd0) &&
                 ((id_ex_registerrt == if_id_register_rs) ||
                  (id_uses_rt && (id_ex_registerrt == if_id_registerrt)));
   end

   // State and down-counter register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and zero-latency output decode; reset forces outputs low.
   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      pc_write         = 1'b1;
      if_id_write      = 1'b1;
      if_flush         = 1'b0;
      id_flush_lwstall = 1'b0;
      id_flush_branch  = 1'b0;
      ex_flush         = 1'b0;
      stall_active     = 1'b0;

      case (state_q)
         RUN: begin
            if (br) begin
               if_flush        = 1'b1;
               id_flush_branch = 1'b1;
               ex_flush        = 1'b1;
               if (BR_MULTI) begin
                  state_d = BR_FLUSH;
                  cnt_d   = BR_INIT;
               end
            end else if (load_use) begin
               id_flush_lwstall = 1'b1;
               pc_write         = 1'b0;
               if_id_write      = 1'b0;
               if (LW_MULTI) begin
                  state_d = LW_STALL;
                  cnt_d   = LW_INIT;
               end
            end
         end

         LW_STALL: begin
            stall_active = 1'b1;
            if (br) begin
               // Redirect wins: the stall is abandoned this cycle.
               if_flush        = 1'b1;
               id_flush_branch = 1'b1;
               ex_flush        = 1'b1;
               if (BR_MULTI) begin
                  state_d = BR_FLUSH;
                  cnt_d   = BR_INIT;
               end else begin
                  state_d = RUN;
                  cnt_d   = '0;
               end
            end else begin
               id_flush_lwstall = 1'b1;
               pc_write         = 1'b0;
               if_id_write      = 1'b0;
               if (cnt_q <= CNT_W'(1)) begin
                  state_d = RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
         end

         BR_FLUSH: begin
            stall_active    = 1'b1;
            if_flush        = 1'b1;
            id_flush_branch = 1'b1;
            ex_flush        = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: begin
            state_d = RUN;
            cnt_d   = '0;
         end
      endcase

      if (!reset) begin
         pc_write         = 1'b0;
         if_id_write      = 1'b0;
         if_flush         = 1'b0;
         id_flush_lwstall = 1'b0;
         id_flush_branch  = 1'b0;
         ex_flush         = 1'b0;
         stall_active     = 1'b0;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Event counters; clear has priority over increment, natural 32-bit wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lwstall_count <= '0;
         flush_count   <= '0;
      end else if (perf_clr) begin
         lwstall_count <= '0;
         flush_count   <= '0;
      end else begin
         if (id_flush_lwstall) lwstall_count <= lwstall_count + 32'd1;
         if (id_flush_branch)  flush_count   <= flush_count + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Testbench for hazard_ctrl_unit: two instances (1/1 and 3/2 cycle settings)
// share stimulus and are compared against a remaining-cycles reference model.
`timescale 1ns/1ps
module tb_hazard_ctrl_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_ex_memread;
   logic [4:0] id_ex_registerrt;
   logic [4:0] if_id_register_rs;
   logic [4:0] if_id_registerrt;
   logic       id_uses_rt;
   logic       mem_branch_taken;
   logic       mem_jump;

   logic pc_write_a, if_id_write_a, if_flush_a, lw_a, brf_a, ex_flush_a, stall_a;
   logic pc_write_b, if_id_write_b, if_flush_b, lw_b, brf_b, ex_flush_b, stall_b;

`ifdef HAZARD_PERF_CNT_EN
   logic        perf_clr;
   logic [31:0] lwc_a, flc_a, lwc_b, flc_b;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_ctrl_unit #(.LOAD_USE_STALLS(1), .BRANCH_FLUSH_CYCLES(1)) dut_a (
      .clk(clk), .reset(reset),
      .id_ex_memread(id_ex_memread), .id_ex_registerrt(id_ex_registerrt),
      .if_id_register_rs(if_id_register_rs), .if_id_registerrt(if_id_registerrt),
      .id_uses_rt(id_uses_rt), .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
      .pc_write(pc_write_a), .if_id_write(if_id_write_a), .if_flush(if_flush_a),
      .id_flush_lwstall(lw_a), .id_flush_branch(brf_a), .ex_flush(ex_flush_a),
      .stall_active(stall_a)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_clr(perf_clr), .lwstall_count(lwc_a), .flush_count(flc_a)
`endif
   );

   hazard_ctrl_unit #(.LOAD_USE_STALLS(3), .BRANCH_FLUSH_CYCLES(2)) dut_b (
      .clk(clk), .reset(reset),
      .id_ex_memread(id_ex_memread), .id_ex_registerrt(id_ex_registerrt),
      .if_id_register_rs(if_id_register_rs), .if_id_registerrt(if_id_registerrt),
      .id_uses_rt(id_uses_rt), .mem_branch_taken(mem_branch_taken), .mem_jump(mem_jump),
      .pc_write(pc_write_b), .if_id_write(if_id_write_b), .if_flush(if_flush_b),
      .id_flush_lwstall(lw_b), .id_flush_branch(brf_b), .ex_flush(ex_flush_b),
      .stall_active(stall_b)
`ifdef HAZARD_PERF_CNT_EN
      , .perf_clr(perf_clr), .lwstall_count(lwc_b), .flush_count(flc_b)
`endif
   );

   // Output bundles: {pc_write, if_id_write, if_flush, lwstall, br_flush, ex_flush, stall_active}
   logic [6:0] obs [2];
   assign obs[0] = {pc_write_a, if_id_write_a, if_flush_a, lw_a, brf_a, ex_flush_a, stall_a};
   assign obs[1] = {pc_write_b, if_id_write_b, if_flush_b, lw_b, brf_b, ex_flush_b, stall_b};

   // Reference model: remaining stall / flush cycles after the current one.
   int          ls_cfg [2] = '{1, 3};
   int          bf_cfg [2] = '{1, 2};
   int          lw_left [2] = '{0, 0};
   int          br_left [2] = '{0, 0};
   int unsigned lw_evt [2] = '{0, 0};
   int unsigned br_evt [2] = '{0, 0};

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic bit hazard_now();
      return id_ex_memread && (id_ex_registerrt != 0) &&
             ((id_ex_registerrt == if_id_register_rs) ||
              (id_uses_rt && (id_ex_registerrt == if_id_registerrt)));
   endfunction

   function automatic logic [6:0] model_out(input int k);
      bit redirect = mem_branch_taken || mem_jump;
      if (!reset)          return 7'b0000000;
      if (br_left[k] > 0)  return 7'b1110111;
      if (redirect)        return {6'b111011, 1'(lw_left[k] > 0)};
      if (lw_left[k] > 0)  return 7'b0001001;
      if (hazard_now())    return 7'b0001000;
      return 7'b1100000;
   endfunction

   task automatic model_step(input int k, input logic [6:0] e);
      bit redirect = mem_branch_taken || mem_jump;
      if (!reset) begin
         lw_left[k] = 0; br_left[k] = 0; lw_evt[k] = 0; br_evt[k] = 0;
      end else begin
`ifdef HAZARD_PERF_CNT_EN
         if (perf_clr) begin
            lw_evt[k] = 0; br_evt[k] = 0;
         end else begin
            lw_evt[k] += 32'(e[3]);
            br_evt[k] += 32'(e[2]);
         end
`else
         lw_evt[k] += 32'(e[3]);
         br_evt[k] += 32'(e[2]);
`endif
         if (br_left[k] > 0) br_left[k]--;
         else if (redirect) begin
            br_left[k] = bf_cfg[k] - 1;
            lw_left[k] = 0;
         end else if (lw_left[k] > 0) lw_left[k]--;
         else if (hazard_now()) lw_left[k] = ls_cfg[k] - 1;
      end
   endtask

   // One cycle: drive after negedge, check combinational outputs, advance model at posedge.
   task automatic cyc(input logic r, input logic m, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic u,
                      input logic bt, input logic jp, input string tag);
      logic [6:0] e [2];
      @(negedge clk);
      reset = r; id_ex_memread = m; id_ex_registerrt = ert;
      if_id_register_rs = rs; if_id_registerrt = rt; id_uses_rt = u;
      mem_branch_taken = bt; mem_jump = jp;
      #1;
      for (int k = 0; k < 2; k++) begin
         e[k] = model_out(k);
         check_val($sformatf("%s_%s", tag, (k == 0) ? "a" : "b"), 32'(obs[k]), 32'(e[k]));
      end
      @(posedge clk);
      for (int k = 0; k < 2; k++) model_step(k, e[k]);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, "idle");
   endtask

   initial begin
      reset = 1'b0; id_ex_memread = 1'b1; id_ex_registerrt = 5'd5;
      if_id_register_rs = 5'd5; if_id_registerrt = 5'd0; id_uses_rt = 1'b0;
      mem_branch_taken = 1'b0; mem_jump = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      // Reset with a live hazard, then release to the no-hazard default.
      cyc(0, 1, 5, 5, 0, 0, 0, 0, "rst_hz");
      cyc(0, 1, 5, 5, 0, 0, 0, 0, "rst_hz2");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "post_rst");
      check_val("pc_write_after_rst", 32'(pc_write_a), 32'd1);

      // Load-use on rs: 1 bubble for a, 3 for b; rt without id_uses_rt and r0 never stall.
      cyc(1, 1, 5, 5, 0, 0, 0, 0, "lu_rs");
      cyc(1, 1, 5, 5, 0, 0, 0, 0, "lu_hold1");
      cyc(1, 1, 5, 5, 0, 0, 0, 0, "lu_hold2");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "lu_done");
      cyc(1, 1, 5, 0, 5, 0, 0, 0, "rt_nouse");
      cyc(1, 1, 5, 0, 5, 1, 0, 0, "rt_use");
      idle(3);
      cyc(1, 1, 0, 0, 0, 1, 0, 0, "r0");

      // Branch beats a simultaneous load-use hazard; jump likewise.
      cyc(1, 1, 7, 7, 0, 0, 1, 0, "br_vs_lu");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "br_tail");
      cyc(1, 1, 7, 0, 7, 1, 0, 1, "jmp_vs_lu");
      idle(2);

      // Branch on the second stall cycle aborts the stall.
      cyc(1, 1, 9, 9, 0, 0, 0, 0, "ab_lu");
      cyc(1, 0, 0, 0, 0, 0, 1, 0, "ab_br");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "ab_flush2");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "ab_run");

      // Reset mid-stall forgets the sequence.
      cyc(1, 1, 3, 3, 0, 0, 0, 0, "ms_lu");
      cyc(0, 0, 0, 0, 0, 0, 0, 0, "ms_rst");
      cyc(1, 0, 0, 0, 0, 0, 0, 0, "ms_run");

      // Randomized traffic with small register ids to provoke matches.
      for (int i = 0; i < 2000; i++) begin
         cyc(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
             1'($urandom_range(0, 1)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 99) < 12) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0,
             "rand");
      end

`ifdef HAZARD_PERF_CNT_EN
      // Counters versus modelled event totals, clear, then wrap from all-ones.
      idle(3);
      check_val("lwc_a", lwc_a, 32'(lw_evt[0]));
      check_val("flc_a", flc_a, 32'(br_evt[0]));
      check_val("lwc_b", lwc_b, 32'(lw_evt[1]));
      check_val("flc_b", flc_b, 32'(br_evt[1]));
      @(negedge clk);
      perf_clr = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
         lw_evt[k] = 0; br_evt[k] = 0;
      end
      @(negedge clk);
      perf_clr = 1'b0;
      check_val("lwc_clr", lwc_a, 32'd0);
      check_val("flc_clr", flc_b, 32'd0);
      @(negedge clk);
      force dut_a.lwstall_count = 32'hFFFF_FFFF;
      #1;
      release dut_a.lwstall_count;
      cyc(1, 1, 4, 4, 0, 0, 0, 0, "wrap_ev");
      #1;
      check_val("lwc_wrap", lwc_a, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
